// File: rtl/instr_issue.sv
// Program memory plus a small sequencer that issues opcode/operand words to the
// execute stage under a valid/ready handshake, then reports done.
module instr_issue #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              prog_we,
    input  logic [ADDR_W-1:0] prog_addr,
    input  logic [17:0]       prog_data,
    input  logic [ADDR_W:0]   prog_len,
    input  logic              start,
    input  logic              instr_ready,
    output logic              instr_valid,
    output logic [1:0]        opcode,
    output logic [7:0]        operand1,
    output logic [7:0]        operand2,
    output logic [ADDR_W-1:0] pc,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_ISSUE,
        S_DONE
    } state_e;

    localparam logic [ADDR_W:0] LEN_MAX = (ADDR_W+1)'(DEPTH);

    state_e            state_q;
    logic [17:0]       mem_q [DEPTH];
    logic [ADDR_W:0]   len_q;
    logic [ADDR_W:0]   len_d;
    logic [ADDR_W-1:0] pc_q;
    logic [1:0]        opcode_q;
    logic [7:0]        operand1_q;
    logic [7:0]        operand2_q;
    logic              valid_q;
    logic              busy_q;
    logic              done_q;
    logic              mem_we;
    logic              last_instr;

    assign len_d      = (prog_len > LEN_MAX) ? LEN_MAX : prog_len;
    assign mem_we     = prog_we && ((state_q == S_IDLE) || (state_q == S_DONE));
    assign last_instr = ({1'b0, pc_q} == (len_q - 1'b1));

    // NOTE: the program memory has no reset so a reset mid-run keeps the loaded
    // program; sequential state is always updated with non-blocking assignments.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[prog_addr] <= prog_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            len_q      <= '0;
            pc_q       <= '0;
            opcode_q   <= '0;
            operand1_q <= '0;
            operand2_q <= '0;
            valid_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        len_q <= len_d;
                        pc_q  <= '0;
                        if (len_d == '0) begin
                            state_q <= S_DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= S_FETCH;
                            busy_q  <= 1'b1;
                            done_q  <= 1'b0;
                        end
                    end
                end
                S_FETCH: begin
                    {opcode_q, operand1_q, operand2_q} <= mem_q[pc_q];
                    valid_q <= 1'b1;
                    state_q <= S_ISSUE;
                end
                S_ISSUE: begin
                    // Outputs hold until the consumer takes the word.
                    if (instr_ready) begin
                        valid_q <= 1'b0;
                        if (last_instr) begin
                            state_q <= S_DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            pc_q    <= pc_q + 1'b1;
                            state_q <= S_FETCH;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign instr_valid = valid_q;
    assign opcode      = opcode_q;
    assign operand1    = operand1_q;
    assign operand2    = operand2_q;
    assign pc          = pc_q;
    assign busy        = busy_q;
    assign done        = done_q;

endmodule

// File: tb/tb_instr_issue.sv
// Randomized bench for instr_issue: an array model of program memory and an
// index of the next expected instruction predict every issued word.
module tb_instr_issue;

    localparam int DEPTH  = 16;
    localparam int ADDR_W = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic              prog_we;
    logic [ADDR_W-1:0] prog_addr;
    logic [17:0]       prog_data;
    logic [ADDR_W:0]   prog_len;
    logic              start;
    logic              instr_ready;
    logic              instr_valid;
    logic [1:0]        opcode;
    logic [7:0]        operand1;
    logic [7:0]        operand2;
    logic [ADDR_W-1:0] pc;
    logic              busy;
    logic              done;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [17:0] model_mem [DEPTH];

    always #5 clk = ~clk;

    instr_issue #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .prog_we    (prog_we),
        .prog_addr  (prog_addr),
        .prog_data  (prog_data),
        .prog_len   (prog_len),
        .start      (start),
        .instr_ready(instr_ready),
        .instr_valid(instr_valid),
        .opcode     (opcode),
        .operand1   (operand1),
        .operand2   (operand2),
        .pc         (pc),
        .busy       (busy),
        .done       (done)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_mem(input int a, input logic [17:0] d);
        prog_we   = 1'b1;
        prog_addr = a[ADDR_W-1:0];
        prog_data = d;
        tick();
        prog_we = 1'b0;
        model_mem[a] = d;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_valid"}, instr_valid, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_pc"}, pc, 0);
        check({tag, "_instr"}, {opcode, operand1, operand2}, 0);
    endtask

    function automatic logic [17:0] word(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
        return {op, a, b};
    endfunction

    // Issues a program of len words with random backpressure, random stray
    // starts and random stray writes; optionally resets while word abort_at is valid.
    task automatic run_program(input int len, input int ready_pct, input int abort_at);
        int          eff;
        int          k;
        int          cyc;
        bit          hs;
        bit          hold;
        logic [17:0] prev_instr;
        logic [3:0]  prev_pc;
        eff = (len > DEPTH) ? DEPTH : len;
        k   = 0;
        cyc = 0;
        prog_len = len[ADDR_W:0];
        start    = 1'b1;
        tick();
        start = 1'b0;
        if (eff == 0) begin
            check("len0_done", done, 1);
            check("len0_valid", instr_valid, 0);
            check("len0_busy", busy, 0);
            check("len0_pc", pc, 0);
            return;
        end
        check("fetch_valid", instr_valid, 0);
        while (k < eff && cyc < 400) begin
            check("busy", busy, 1);
            if (instr_valid) begin
                check("pc", pc, k);
                check("instr", {opcode, operand1, operand2}, model_mem[k]);
                if (abort_at == k) begin
                    instr_ready = 1'b0;
                    reset       = 1'b0;
                    tick();
                    reset = 1'b1;
                    check_reset_state("abort");
                    return;
                end
            end
            instr_ready = ($urandom_range(0, 99) < ready_pct);
            start       = ($urandom_range(0, 7) == 0);
            prog_len    = 5'($urandom_range(0, 20));
            prog_we     = ($urandom_range(0, 3) == 0);
            prog_addr   = 4'($urandom_range(0, DEPTH - 1));
            prog_data   = 18'($urandom);
            hs          = instr_valid && instr_ready;
            hold        = instr_valid && !instr_ready;
            prev_instr  = {opcode, operand1, operand2};
            prev_pc     = pc;
            tick();
            cyc++;
            start   = 1'b0;
            prog_we = 1'b0;
            if (hs) begin
                k++;
                if (k < eff) check("gap_valid", instr_valid, 0);
            end else if (hold) begin
                check("hold", {instr_valid, pc, opcode, operand1, operand2}, {1'b1, prev_pc, prev_instr});
            end
        end
        instr_ready = 1'b0;
        if (k < eff) begin
            check("timeout_issued", k, eff);
        end else begin
            check("end_done", done, 1);
            check("end_busy", busy, 0);
            check("end_valid", instr_valid, 0);
            check("end_pc", pc, eff - 1);
            check("end_instr", {opcode, operand1, operand2}, model_mem[eff - 1]);
        end
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [17:0] saved;
        reset       = 1'b0;
        prog_we     = 1'b0;
        prog_addr   = '0;
        prog_data   = '0;
        prog_len    = '0;
        start       = 1'b0;
        instr_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;

        // Reset held for two cycles.
        tick();
        tick();
        reset = 1'b1;
        check_reset_state("reset");
        for (int i = 0; i < DEPTH; i++) write_mem(i, 18'($urandom));

        // Two-instruction program with exact cycle timing.
        write_mem(0, word(2'b01, 8'h05, 8'h03));
        write_mem(1, word(2'b10, 8'h09, 8'h04));
        instr_ready = 1'b1;
        prog_len    = 5'd2;
        start       = 1'b1;
        tick();
        start = 1'b0;
        check("t2_c1_valid", instr_valid, 0);
        check("t2_c1_busy", busy, 1);
        tick();
        check("t2_c2_valid", instr_valid, 1);
        check("t2_c2_instr", {opcode, operand1, operand2}, 18'h1_0503);
        tick();
        check("t2_c3_valid", instr_valid, 0);
        check("t2_c3_pc", pc, 1);
        tick();
        check("t2_c4_valid", instr_valid, 1);
        check("t2_c4_instr", {opcode, operand1, operand2}, 18'h2_0904);
        tick();
        check("t2_c5_done", done, 1);
        check("t2_c5_valid", instr_valid, 0);
        check("t2_c5_busy", busy, 0);
        check("t2_c5_pc", pc, 1);

        // Backpressure: five stalled cycles then accept.
        instr_ready = 1'b0;
        start       = 1'b1;
        tick();
        start = 1'b0;
        tick();
        saved = {opcode, operand1, operand2};
        check("bp_first", saved, model_mem[0]);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_hold", {instr_valid, pc, opcode, operand1, operand2}, {1'b1, 4'd0, model_mem[0]});
        end
        instr_ready = 1'b1;
        tick();
        check("bp_pc_adv", pc, 1);
        check("bp_gap", instr_valid, 0);
        tick();
        tick();
        check("bp_done", done, 1);
        instr_ready = 1'b0;

        // Zero-length program.
        run_program(0, 100, -1);

        // Full-depth program, then an over-long length that must clamp.
        write_mem(15, word(2'b11, 8'hFF, 8'h01));
        run_program(16, 70, -1);
        run_program(25, 50, -1);

        // Reset mid-issue, then rerun to confirm memory survived.
        run_program(6, 40, 3);
        run_program(6, 60, -1);

        // Write and start in the same cycle: first fetch sees the new word.
        prog_we   = 1'b1;
        prog_addr = '0;
        prog_data = word(2'b10, 8'hA5, 8'h5A);
        prog_len  = 5'd1;
        start     = 1'b1;
        tick();
        model_mem[0] = word(2'b10, 8'hA5, 8'h5A);
        prog_we = 1'b0;
        start   = 1'b0;
        tick();
        check("ws_instr", {instr_valid, opcode, operand1, operand2}, {1'b1, model_mem[0]});
        instr_ready = 1'b1;
        tick();
        check("ws_done", done, 1);
        instr_ready = 1'b0;

        // Random programs with random reload of a few words between runs.
        for (int r = 0; r < 30; r++) begin
            for (int w = 0; w < int'($urandom_range(0, 4)); w++) begin
                write_mem(int'($urandom_range(0, DEPTH - 1)), 18'($urandom));
            end
            run_program(int'($urandom_range(0, 18)), int'($urandom_range(20, 100)), -1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
